instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  single-cycle instruction-memory read request.
REQ-006 imem_addr  output  32  read address; equals PC while imem_req=1, otherwise don't-care.
REQ-007 imem_rvalid  input  1  read data valid.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 Instr  output  32  instruction presented to decode.
REQ-010 PC  output  32  address of the presented Instr.
REQ-011 instr_valid  output  1  Instr/PC valid.
REQ-012 instr_ready  input  1  decode/execute accepts Instr this cycle.
REQ-013 redirect  input  1  accepted instruction is a taken branch.
REQ-014 branch_target  input  32  next PC when redirect=1.
REQ-015 fetch_err  output  1  sticky misaligned-target error (see Configuration).

Function
REQ-016 States SHALL be FETCH, WAIT, HOLD and, with the macro, HALT.
REQ-017 FETCH: imem_req=1 and imem_addr=PC for exactly one cycle; next state WAIT.
REQ-018 WAIT: imem_req=0; on imem_rvalid=1, Instr<=imem_rdata, instr_valid<=1, next state HOLD; otherwise stay in WAIT with no timeout.
REQ-019 HOLD: instr_valid=1; on instr_ready=1 (handshake), instr_valid<=0 and next state FETCH.
REQ-020 At handshake, PC<=branch_target if redirect=1, else PC<=PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-021 redirect and branch_target SHALL be ignored in every cycle without a handshake.
REQ-022 imem_rvalid SHALL be ignored outside WAIT; at most one request is outstanding.
REQ-023 Instr and PC SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-024 instr_ready=1 while instr_valid=0 SHALL have no effect.
REQ-025 Minimum latency: request in cycle N, rvalid earliest N+1, instr_valid=1 from N+2, next request N+3 when ready is high at N+2; peak throughput is one instruction per 3 cycles.
REQ-026 When instr_valid=0, Instr SHALL read 32'h0000_0013 (NOP) so downstream decode produces no writes.
REQ-027 The instruction memory SHALL be reset by the same rst, so no response to a pre-reset request arrives after reset.

Reset
REQ-028 While rst=1 at a clock edge: PC<=RESET_PC, state<=FETCH, instr_valid<=0, Instr<=32'h0000_0013, fetch_err<=0.
REQ-029 imem_req SHALL be 0 during any cycle in which rst=1; the first request SHALL issue in the first cycle after rst deasserts.
REQ-030 Reset asserted in any state, including mid-WAIT or HOLD, SHALL abort the operation and discard the pending instruction.

Configuration
REQ-031 Macro FETCH_ALIGN_CHECK_EN SHALL select misaligned-target handling.
REQ-032 With FETCH_ALIGN_CHECK_EN: a handshake with redirect=1 and branch_target[1:0]!=2'b00 SHALL set fetch_err<=1, load PC<=branch_target, and enter HALT.
REQ-033 In HALT: imem_req=0 and instr_valid=0; fetch_err stays 1 until reset.
REQ-034 Without FETCH_ALIGN_CHECK_EN: PC<={branch_target[31:2],2'b00}, fetch_err is tied to 0, and no HALT state exists.

Verification
REQ-035 Reset release, RESET_PC=0, memory rvalid 1 cycle after req, ready held 1 -> requests at addresses 0, 4, 8 every 3 cycles; Instr matches memory.
REQ-036 rvalid delayed 5 cycles, ready low 4 cycles in HOLD -> imem_req stays 0, Instr/PC unchanged, exactly one request per instruction.
REQ-037 Handshake at PC=0x10 with redirect=1, target=0x40 -> next imem_addr=0x40; redirect pulsed with instr_valid=0 -> ignored, next address PC+4.
REQ-038 PC=0xFFFF_FFFC, handshake without redirect -> next imem_addr=0x0000_0000.
REQ-039 Macro defined, redirect target=0x42 -> fetch_err=1, no further requests until rst; macro undefined -> next imem_addr=0x40, fetch_err=0.
REQ-040 rst asserted one cycle mid-WAIT -> instr_valid=0, Instr=0x0000_0013, next request at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem read, result held for decode until accepted.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned branch targets into a sticky HALT state.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] branch_target,
    output logic        fetch_err,
    output logic [1:0]  o_dbg_state
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
`ifdef FETCH_ALIGN_CHECK_EN
        ST_HALT  = 2'd3,
`endif
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] w_next_pc;
    logic        w_handshake;

    // Handshake: an instruction transfers on a cycle where instr_valid && instr_ready;
    // valid never drops and Instr/PC never change until that transfer happens.
    assign w_handshake = (r_state == ST_HOLD) && instr_ready;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_err;
    logic w_misalign;
    assign w_misalign = redirect && (branch_target[1:0] != 2'b00);
    assign w_next_pc  = redirect ? branch_target : r_pc + 32'd4;
    assign fetch_err  = r_err;
`else
    assign w_next_pc  = redirect ? (branch_target & 32'hFFFF_FFFC) : r_pc + 32'd4;
    assign fetch_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: w_next_state = ST_WAIT;
            ST_WAIT:  if (imem_rvalid) w_next_state = ST_HOLD;
            ST_HOLD: begin
                if (instr_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    w_next_state = w_misalign ? ST_HALT : ST_FETCH;
`else
                    w_next_state = ST_FETCH;
`endif
                end
            end
            default:  w_next_state = r_state;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == ST_FETCH) && !rst;
        imem_addr   = r_pc;
        instr_valid = r_valid;
        Instr       = r_valid ? r_instr : NOP;
        PC          = r_pc;
        o_dbg_state = r_state;
    end

    // Datapath: capture the response in WAIT, advance PC only on the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= NOP;
`ifdef FETCH_ALIGN_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            if ((r_state == ST_WAIT) && imem_rvalid) begin
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_valid <= 1'b0;
                r_instr <= NOP;
                r_pc    <= w_next_pc;
`ifdef FETCH_ALIGN_CHECK_EN
                if (w_misalign) r_err <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responder with programmable latency,
// request-address scoreboard and per-instruction handshake checks.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        fetch_err;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_addr[$];
    int          obs_cyc[$];
    int          rd_idx = 0;

    int          mem_delay = 1;
    int          pend_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        stray = 1'b0;
    int          cyc = 0;
    int          rst_req_bad = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .Instr        (Instr),
        .PC           (PC),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .branch_target(branch_target),
        .fetch_err    (fetch_err),
        .o_dbg_state  (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model and request monitor, evaluated mid-cycle
    always @(negedge clk) begin
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        if (rst) begin
            pend = 1'b0;
            if (imem_req) rst_req_bad++;
        end else begin
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                    pend        = 1'b0;
                end
            end
            if (imem_req) begin
                obs_addr.push_back(imem_addr);
                obs_cyc.push_back(cyc);
                pend      = 1'b1;
                pend_cnt  = mem_delay;
                pend_addr = imem_addr;
            end
            if (stray) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hBAD0_BAD0;
            end
        end
    end

    // Scoreboard
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reqs();
        while (rd_idx < obs_addr.size()) begin
            if (exp_q.size() == 0) check_val("req_unexpected", obs_addr[rd_idx], 32'hFFFF_FFFF);
            else                   check_val("req_addr", obs_addr[rd_idx], exp_q.pop_front());
            rd_idx++;
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60; i++) begin
            if (instr_valid) break;
            step();
        end
        check_val("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic fetch_one(input logic [31:0] exp_pc, input int hold, input logic redir,
                             input logic [31:0] tgt, input logic [31:0] exp_next, input bit push);
        wait_valid();
        check_reqs();
        check_val("pc", PC, exp_pc);
        check_val("instr", Instr, mem_word(exp_pc));
        if (hold > 0) stray = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            stray = 1'b0;
            check_val("hold_valid", 32'(instr_valid), 32'd1);
            check_val("hold_pc", PC, exp_pc);
            check_val("hold_instr", Instr, mem_word(exp_pc));
            check_val("hold_req", 32'(imem_req), 32'd0);
        end
        if (push) exp_q.push_back(exp_next);
        instr_ready   = 1'b1;
        redirect      = redir;
        branch_target = tgt;
        step();
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        branch_target = 32'hDEAD_BEE0;
        check_val("hs_valid", 32'(instr_valid), 32'd0);
        check_val("hs_nop", Instr, NOP);
        check_val("next_pc", PC, exp_next);
    endtask

    initial begin
        repeat (3) step();
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_instr", Instr, NOP);
        check_val("rst_pc", PC, 32'h0);
        check_val("rst_err", 32'(fetch_err), 32'd0);
        check_val("rst_req", 32'(imem_req), 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'd0);
        exp_q.push_back(32'h0);
        rst = 1'b0;

        // Back-to-back fetches, 1-cycle memory, ready always high
        fetch_one(32'h0, 0, 1'b0, 32'h0, 32'h4, 1'b1);
        fetch_one(32'h4, 0, 1'b0, 32'h0, 32'h8, 1'b1);
        mem_delay = 5;
        fetch_one(32'h8, 0, 1'b0, 32'h0, 32'hC, 1'b1);
        check_val("req_spacing_01", 32'(obs_cyc[1] - obs_cyc[0]), 32'd3);
        check_val("req_spacing_12", 32'(obs_cyc[2] - obs_cyc[1]), 32'd3);

        // Slow memory plus a stalled consumer with a stray rvalid
        mem_delay = 3;
        fetch_one(32'hC, 4, 1'b0, 32'h0, 32'h10, 1'b1);

        // Taken branch, then redirect/ready pulsed while nothing is valid
        fetch_one(32'h10, 0, 1'b1, 32'h40, 32'h40, 1'b1);
        instr_ready   = 1'b1;
        redirect      = 1'b1;
        branch_target = 32'h80;
        step();
        check_val("pulse_valid0", 32'(instr_valid), 32'd0);
        step();
        check_val("pulse_valid1", 32'(instr_valid), 32'd0);
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        mem_delay     = 1;
        fetch_one(32'h40, 0, 1'b0, 32'h0, 32'h44, 1'b1);

        // PC wrap at the top of the address space
        fetch_one(32'h44, 0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        fetch_one(32'hFFFF_FFFC, 0, 1'b0, 32'h0000_1230, 32'h0, 1'b1);

        // Misaligned branch target
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_one(32'h0, 0, 1'b1, 32'h42, 32'h42, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_reqs();
        end
        check_val("halt_err", 32'(fetch_err), 32'd1);
        check_val("halt_valid", 32'(instr_valid), 32'd0);
        check_val("halt_state", 32'(dbg_state), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("halt_rst_err", 32'(fetch_err), 32'd0);
        exp_q.push_back(32'h0);
        mem_delay = 4;
        fetch_one(32'h0, 0, 1'b0, 32'h0, 32'h4, 1'b1);
`else
        fetch_one(32'h0, 0, 1'b1, 32'h42, 32'h40, 1'b1);
        check_val("noalign_err", 32'(fetch_err), 32'd0);
        mem_delay = 4;
        fetch_one(32'h40, 0, 1'b0, 32'h0, 32'h44, 1'b1);
`endif

        // Reset for one cycle while waiting on memory
        check_val("pre_rst_req", 32'(imem_req), 32'd1);
        step();
        check_val("mid_wait_state", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("wrst_valid", 32'(instr_valid), 32'd0);
        check_val("wrst_instr", Instr, NOP);
        check_val("wrst_pc", PC, 32'h0);
        check_val("wrst_err", 32'(fetch_err), 32'd0);
        check_val("wrst_state", 32'(dbg_state), 32'd0);
        exp_q.push_back(32'h0);
        mem_delay = 1;
        fetch_one(32'h0, 0, 1'b0, 32'h0, 32'h4, 1'b1);

        repeat (5) step();
        check_reqs();
        check_val("req_missing", 32'(exp_q.size()), 32'd0);
        check_val("req_during_rst", 32'(rst_req_bad), 32'd0);
        check_val("req_total", 32'(obs_addr.size()), 32'd13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
